// File: rtl/tlb_data_demux_if.sv
// Sequence-entry, shared input stream and per-region output stream signals of the data demux.
interface tlb_data_demux_if #(
  parameter int N_REGIONS      = 4,
  parameter int N_REGIONS_BITS = 2,
  parameter int DATA_BITS      = 512,
  parameter int BLEN_BITS      = 22
);
  logic                      s_mux_valid;
  logic                      s_mux_ready;
  logic [N_REGIONS_BITS-1:0] s_mux_vfid;
  logic [BLEN_BITS-1:0]      s_mux_len;
  logic                      s_mux_ctl;

  logic                      s_axis_tvalid;
  logic                      s_axis_tready;
  logic [DATA_BITS-1:0]      s_axis_tdata;
  logic [DATA_BITS/8-1:0]    s_axis_tkeep;
  logic                      s_axis_tlast;

  logic [N_REGIONS-1:0]      m_axis_tvalid;
  logic [N_REGIONS-1:0]      m_axis_tready;
  logic [DATA_BITS-1:0]      m_axis_tdata;
  logic [DATA_BITS/8-1:0]    m_axis_tkeep;
  logic                      m_axis_tlast;

  modport master (
    output s_mux_valid, s_mux_vfid, s_mux_len, s_mux_ctl,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output m_axis_tready,
    input  s_mux_ready, s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport slave (
    input  s_mux_valid, s_mux_vfid, s_mux_len, s_mux_ctl,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  m_axis_tready,
    output s_mux_ready, s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/tlb_data_demux.sv
// Routes len+1 beats of the shared stream to the region named by each sequence entry.
// Zero-latency datapath; region backpressure stalls only the shared input, next entry waits for the last beat.
module tlb_data_demux #(
  parameter int N_REGIONS      = 4,
  parameter int N_REGIONS_BITS = 2,
  parameter int DATA_BITS      = 512,
  parameter int BLEN_BITS      = 22
) (
  input  logic            aclk,
  input  logic            aresetn,
  tlb_data_demux_if.slave bus,
  output logic [31:0]     xfer_cnt,
  output logic            err_vfid
);
  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [N_REGIONS_BITS:0] NREG = (N_REGIONS_BITS + 1)'(N_REGIONS);

  state_t                    state;
  state_t                    state_nxt;
  logic [N_REGIONS_BITS-1:0] vfid_reg;
  logic [BLEN_BITS-1:0]      len_reg;
  logic [BLEN_BITS-1:0]      cnt;
  logic                      ctl_reg;
  logic                      in_range;
  logic                      last_beat;
  logic                      region_rdy;
  logic                      hs;
  logic                      load;
  logic                      unused_tlast;

  // Transfer boundaries come only from the sequence entries.
  assign unused_tlast = bus.s_axis_tlast;

  assign in_range  = {1'b0, vfid_reg} < NREG;
  assign last_beat = (cnt == len_reg);

  assign bus.m_axis_tdata = bus.s_axis_tdata;
  assign bus.m_axis_tkeep = bus.s_axis_tkeep;

  always_comb begin
    region_rdy = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (vfid_reg == N_REGIONS_BITS'(i)) region_rdy = bus.m_axis_tready[i];
    end
  end

  always_comb begin
    state_nxt         = state;
    bus.s_mux_ready   = 1'b0;
    bus.s_axis_tready = 1'b0;
    bus.m_axis_tvalid = '0;
    bus.m_axis_tlast  = 1'b0;
    hs                = 1'b0;
    load              = 1'b0;
    case (state)
      IDLE: begin
        bus.s_mux_ready = 1'b1;
        if (bus.s_mux_valid) begin
          load      = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        for (int i = 0; i < N_REGIONS; i++) begin
          bus.m_axis_tvalid[i] = bus.s_axis_tvalid && (vfid_reg == N_REGIONS_BITS'(i));
        end
        // Out-of-range destinations sink their beats so the sequence keeps moving.
        bus.s_axis_tready = in_range ? region_rdy : 1'b1;
        bus.m_axis_tlast  = last_beat && ctl_reg;
        hs                = bus.s_axis_tvalid && bus.s_axis_tready;
        if (hs && last_beat) begin
          bus.s_mux_ready = 1'b1;
          if (bus.s_mux_valid) load = 1'b1;
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      vfid_reg <= '0;
      len_reg  <= '0;
      ctl_reg  <= 1'b0;
      cnt      <= '0;
      xfer_cnt <= '0;
      err_vfid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        vfid_reg <= bus.s_mux_vfid;
        len_reg  <= bus.s_mux_len;
        ctl_reg  <= bus.s_mux_ctl;
        cnt      <= '0;
        if ({1'b0, bus.s_mux_vfid} >= NREG) err_vfid <= 1'b1;
      end else if (hs && !last_beat) begin
        cnt <= cnt + BLEN_BITS'(1);
      end
      if (hs && last_beat) xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_tlb_data_demux.sv
// Randomized bench for tlb_data_demux against a transfer-level reference model.
module tb_tlb_data_demux;
  localparam int NR  = 4;
  localparam int NRB = 3;
  localparam int DW  = 32;
  localparam int KW  = DW / 8;
  localparam int BL  = 6;

  typedef struct {
    int vfid;
    int len;
    bit ctl;
  } ent_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] xfer_cnt;
  logic        err_vfid;

  tlb_data_demux_if #(.N_REGIONS(NR), .N_REGIONS_BITS(NRB), .DATA_BITS(DW), .BLEN_BITS(BL)) bus ();

  tlb_data_demux #(.N_REGIONS(NR), .N_REGIONS_BITS(NRB), .DATA_BITS(DW), .BLEN_BITS(BL)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave),
    .xfer_cnt(xfer_cnt),
    .err_vfid(err_vfid)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int p_mv = 100, p_sv = 100, p_mr = 100;

  // Reference model: pending entries, the active transfer and beats still owed to it.
  ent_t        ent_q[$];
  bit          m_busy;
  int          m_vfid;
  int          m_left;
  bit          m_ctl;
  logic [31:0] m_xfer;
  bit          m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    ent_q.delete();
    m_busy = 0; m_vfid = 0; m_left = 0; m_ctl = 0; m_xfer = '0; m_err = 0;
  endtask

  task automatic push(input int v, input int l, input bit c);
    ent_t e;
    e.vfid = v; e.len = l; e.ctl = c;
    ent_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    chk({tag, "_tready"}, bus.s_axis_tready, 0);
    chk({tag, "_mux_ready"}, bus.s_mux_ready, 1);
    chk({tag, "_tlast"}, bus.m_axis_tlast, 0);
    chk({tag, "_xfer_cnt"}, xfer_cnt, 0);
    chk({tag, "_err_vfid"}, err_vfid, 0);
  endtask

  // Compare one cycle of DUT outputs with the model, then advance the model past the coming edge.
  task automatic check_step();
    logic [NR-1:0] e_tv;
    bit e_tr, e_tl, e_mr, hs;
    ent_t e;
    chk("xfer_cnt", xfer_cnt, m_xfer);
    chk("err_vfid", err_vfid, m_err);
    e_tv = '0; e_tr = 0; e_tl = 0;
    if (m_busy) begin
      if (m_vfid < NR) begin
        e_tv[m_vfid] = bus.s_axis_tvalid;
        e_tr = bus.m_axis_tready[m_vfid];
      end else begin
        e_tr = 1;
      end
      e_tl = m_ctl && (m_left == 1);
    end
    hs   = m_busy && bus.s_axis_tvalid && e_tr;
    e_mr = !m_busy || (hs && m_left == 1);
    chk("m_tvalid", bus.m_axis_tvalid, e_tv);
    chk("s_tready", bus.s_axis_tready, e_tr);
    chk("m_tlast", bus.m_axis_tlast, e_tl);
    chk("s_mux_ready", bus.s_mux_ready, e_mr);
    chk("m_tdata", bus.m_axis_tdata, bus.s_axis_tdata ^ 0);
    chk("m_tkeep", bus.m_axis_tkeep, bus.s_axis_tkeep ^ 0);
    if (hs) begin
      m_left--;
      if (m_left == 0) begin
        m_xfer = m_xfer + 32'd1;
        m_busy = 0;
      end
    end
    if (e_mr && bus.s_mux_valid) begin
      e = ent_q.pop_front();
      m_busy = 1; m_vfid = e.vfid; m_left = e.len + 1; m_ctl = e.ctl;
      if (e.vfid >= NR) m_err = 1;
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
    bus.s_mux_valid = (ent_q.size() != 0) && ($urandom_range(99) < p_mv);
    if (ent_q.size() != 0) begin
      bus.s_mux_vfid = NRB'(ent_q[0].vfid);
      bus.s_mux_len  = BL'(ent_q[0].len);
      bus.s_mux_ctl  = ent_q[0].ctl;
    end
    bus.s_axis_tvalid = $urandom_range(99) < p_sv;
    bus.s_axis_tdata  = DW'($urandom);
    bus.s_axis_tkeep  = KW'($urandom);
    bus.s_axis_tlast  = 1'($urandom_range(1));
    for (int i = 0; i < NR; i++) bus.m_axis_tready[i] = $urandom_range(99) < p_mr;
    @(negedge aclk);
    check_step();
  endtask

  task automatic run_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((ent_q.size() != 0 || m_busy) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, (ent_q.size() != 0 || m_busy), 0);
    cycle();
  endtask

  initial begin
    aresetn = 1'b0;
    bus.s_mux_valid = 0; bus.s_mux_vfid = '0; bus.s_mux_len = '0; bus.s_mux_ctl = 0;
    bus.s_axis_tvalid = 1; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = 0;
    bus.m_axis_tready = '1;
    reset_model();
    #3;
    check_reset_outputs("rst");
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single 4-beat transfer to region 2 with tlast on the final beat.
    push(2, 3, 1);
    run_idle("t1", 50);
    chk("t1_xfer_cnt", xfer_cnt, 1);

    // Back-to-back entries with no bubble between them.
    push(0, 0, 0);
    push(1, 1, 1);
    run_idle("t2", 50);
    chk("t2_xfer_cnt", xfer_cnt, 3);

    // Region 1 backpressure for 5 cycles mid-transfer.
    push(1, 5, 1);
    cycle(); cycle(); cycle();
    p_mr = 0;
    repeat (5) cycle();
    p_mr = 100;
    run_idle("t3", 50);

    // Out-of-range destination sinks its beats; error stays sticky.
    push(5, 1, 0);
    push(2, 0, 1);
    run_idle("t4", 50);
    chk("t4_err_vfid", err_vfid, 1);

    // Longest transfer the length field allows.
    push(3, (1 << BL) - 1, 1);
    run_idle("tmax", 200);

    // Random traffic with random stalls on every side.
    p_mv = 80; p_sv = 70; p_mr = 70;
    for (int k = 0; k < 200; k++)
      push($urandom_range(0, 7), $urandom_range(0, 5), 1'($urandom_range(1)));
    run_idle("rand", 20000);

    // Reset asserted after two beats of an 8-beat transfer.
    p_mv = 100; p_sv = 100; p_mr = 100;
    push(1, 7, 1);
    for (int n = 0; n < 20 && !(m_busy && m_left == 6); n++) cycle();
    chk("mid_rst_reached", (m_busy && m_left == 6), 1);
    #2 aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    reset_model();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    push(3, 0, 1);
    run_idle("post_rst", 50);
    chk("post_rst_xfer_cnt", xfer_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
